alu_ctrl: RTL and testbench

ALU_CTRL -- requirements
Module: alu_ctrl

---
 rtl/alu_ctrl.sv | 240 ++++++++++++++++++++++++
 tb/tb_alu_ctrl.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl.sv
// -----------------------------------------------------------------------------
// alu_ctrl
// Handshaked ALU controller. A command (opcode + two operands) is captured in
// IDLE, evaluated in EXEC from the captured copy, and the result is held in
// HOLD until the consumer accepts it. Two statistics counters track completed
// results and completed results flagged with error or overflow.
//
// Ports
//   i_clk        clock, all state changes on the rising edge
//   i_rst_n      asynchronous active-low reset
//   i_valid      command valid            o_ready   controller accepts command
//   i_op         opcode (0 sub, 1 nand, 2 starting-ones, 3 one-hot, 4-7 illegal)
//   i_a, i_b     operands (WIDTH bits)
//   o_valid      result valid             i_ready   consumer accepts result
//   o_y          result (WIDTH bits)
//   o_overflow   overflow flag            o_err     error flag
//   i_clr_stats  synchronous clear of both statistics counters
//   o_ops_cnt    completed handshakes (wraps)
//   o_bad_cnt    completed handshakes with err|overflow (saturates)
// -----------------------------------------------------------------------------
module alu_ctrl #(
   parameter int WIDTH = 4,
   parameter int CNT_W = 8
) (
   input  logic             i_clk,
   input  logic             i_rst_n,
   input  logic             i_valid,
   output logic             o_ready,
   input  logic [2:0]       i_op,
   input  logic [WIDTH-1:0] i_a,
   input  logic [WIDTH-1:0] i_b,
   output logic             o_valid,
   input  logic             i_ready,
   output logic [WIDTH-1:0] o_y,
   output logic             o_overflow,
   output logic             o_err,
   input  logic             i_clr_stats,
   output logic [CNT_W-1:0] o_ops_cnt,
   output logic [CNT_W-1:0] o_bad_cnt
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      EXEC = 2'd1,
      HOLD = 2'd2
   } state_t;

   // Largest index/count that fits in the result field.
   localparam logic [31:0]      Y_MAX   = (32'd1 << WIDTH) - 32'd1;
   localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   state_t           state_r;
   state_t           state_s;
   logic [2:0]       op_r;
   logic [WIDTH-1:0] a_r;
   logic [WIDTH-1:0] b_r;
   logic [WIDTH-1:0] y_r;
   logic             ov_r;
   logic             err_r;
   logic [CNT_W-1:0] ops_cnt_r;
   logic [CNT_W-1:0] bad_cnt_r;

   logic             done_s;
   logic [WIDTH-1:0] diff_s;
   logic [31:0]      ones_s;
   logic [31:0]      idx_s;
   logic [31:0]      pop_s;
   logic [WIDTH-1:0] unit_y_s;
   logic             unit_ov_s;
   logic             unit_err_s;

   // Number of consecutive 1s counted down from the MSB.
   function automatic logic [31:0] lead_ones(input logic [2*WIDTH-1:0] v);
      logic [31:0] cnt;
      logic        run;
      cnt = 32'd0;
      run = 1'b1;
      for (int i = 2*WIDTH-1; i >= 0; i--) begin
         if (run && v[i]) begin
            cnt = cnt + 32'd1;
         end else begin
            run = 1'b0;
         end
      end
      return cnt;
   endfunction

   // Index of the lowest set bit, 0 when the vector is all zeros.
   function automatic logic [31:0] low_index(input logic [2*WIDTH-1:0] v);
      logic [31:0] idx;
      logic        found;
      idx   = 32'd0;
      found = 1'b0;
      for (int i = 0; i < 2*WIDTH; i++) begin
         if (!found && v[i]) begin
            idx = 32'(i);
         end else begin
            idx = idx;
         end
         found = found | v[i];
      end
      return idx;
   endfunction

   // Population count, used to detect a non-one-hot operand pair.
   function automatic logic [31:0] pop_count(input logic [2*WIDTH-1:0] v);
      logic [31:0] cnt;
      cnt = 32'd0;
      for (int i = 0; i < 2*WIDTH; i++) begin
         cnt = cnt + {31'd0, v[i]};
      end
      return cnt;
   endfunction

   // State register.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_s;
      end
   end

   // Next-state decode and result-handshake strobe.
   always_comb begin
      state_s = state_r;
      done_s  = 1'b0;
      case (state_r)
         IDLE: begin
            if (i_valid) begin
               state_s = EXEC;
            end else begin
               state_s = IDLE;
            end
         end
         EXEC: begin
            state_s = HOLD;
         end
         HOLD: begin
            if (i_ready) begin
               state_s = IDLE;
               done_s  = 1'b1;
            end else begin
               state_s = HOLD;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // Functional units, all fed from the captured command so that input
   // changes outside IDLE cannot disturb a result in flight.
   always_comb begin
      diff_s     = a_r - b_r;
      ones_s     = lead_ones({b_r, a_r});
      idx_s      = low_index({b_r, a_r});
      pop_s      = pop_count({b_r, a_r});
      unit_y_s   = {WIDTH{1'b0}};
      unit_ov_s  = 1'b0;
      unit_err_s = 1'b0;
      case (op_r)
         3'd0: begin
            unit_y_s  = diff_s;
            // Signed overflow: operand signs differ and the result sign
            // does not follow A.
            unit_ov_s = (a_r[WIDTH-1] != b_r[WIDTH-1]) &&
                        (diff_s[WIDTH-1] != a_r[WIDTH-1]);
         end
         3'd1: begin
            unit_y_s = ~(a_r & b_r);
         end
         3'd2: begin
            unit_y_s  = ones_s[WIDTH-1:0];
            unit_ov_s = (ones_s > Y_MAX);
         end
         3'd3: begin
            unit_y_s   = idx_s[WIDTH-1:0];
            unit_ov_s  = (idx_s > Y_MAX);
            unit_err_s = (pop_s > 32'd1);
         end
         default: begin
            unit_err_s = 1'b1;
         end
      endcase
   end

   // Command capture in IDLE.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         op_r <= 3'd0;
         a_r  <= {WIDTH{1'b0}};
         b_r  <= {WIDTH{1'b0}};
      end else if ((state_r == IDLE) && i_valid) begin
         op_r <= i_op;
         a_r  <= i_a;
         b_r  <= i_b;
      end
   end

   // Result registers, loaded once in EXEC and held through HOLD.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         y_r   <= {WIDTH{1'b0}};
         ov_r  <= 1'b0;
         err_r <= 1'b0;
      end else if (state_r == EXEC) begin
         y_r   <= unit_y_s;
         ov_r  <= unit_ov_s;
         err_r <= unit_err_s;
      end
   end

   // Statistics counters; clear wins over a same-edge completion.
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         ops_cnt_r <= {CNT_W{1'b0}};
         bad_cnt_r <= {CNT_W{1'b0}};
      end else if (i_clr_stats) begin
         ops_cnt_r <= {CNT_W{1'b0}};
         bad_cnt_r <= {CNT_W{1'b0}};
      end else if (done_s) begin
         ops_cnt_r <= ops_cnt_r + CNT_ONE;
         if ((err_r || ov_r) && (bad_cnt_r != CNT_MAX)) begin
            bad_cnt_r <= bad_cnt_r + CNT_ONE;
         end
      end
   end

   assign o_ready    = (state_r == IDLE);
   assign o_valid    = (state_r == HOLD);
   assign o_y        = y_r;
   assign o_overflow = ov_r;
   assign o_err      = err_r;
   assign o_ops_cnt  = ops_cnt_r;
   assign o_bad_cnt  = bad_cnt_r;

endmodule

// File: tb/tb_alu_ctrl.sv
// -----------------------------------------------------------------------------
// tb_alu_ctrl
// Directed self-checking bench for alu_ctrl (WIDTH=4, CNT_W=8). Inputs are
// driven just after the falling edge, outputs sampled at the falling edge.
// -----------------------------------------------------------------------------
module tb_alu_ctrl;

   logic       i_clk;
   logic       i_rst_n;
   logic       i_valid;
   logic       o_ready;
   logic [2:0] i_op;
   logic [3:0] i_a;
   logic [3:0] i_b;
   logic       o_valid;
   logic       i_ready;
   logic [3:0] o_y;
   logic       o_overflow;
   logic       o_err;
   logic       i_clr_stats;
   logic [7:0] o_ops_cnt;
   logic [7:0] o_bad_cnt;

   int total = 0;
   int bad   = 0;

   alu_ctrl #(.WIDTH(4), .CNT_W(8)) dut (
      .i_clk       (i_clk),
      .i_rst_n     (i_rst_n),
      .i_valid     (i_valid),
      .o_ready     (o_ready),
      .i_op        (i_op),
      .i_a         (i_a),
      .i_b         (i_b),
      .o_valid     (o_valid),
      .i_ready     (i_ready),
      .o_y         (o_y),
      .o_overflow  (o_overflow),
      .o_err       (o_err),
      .i_clr_stats (i_clr_stats),
      .o_ops_cnt   (o_ops_cnt),
      .o_bad_cnt   (o_bad_cnt)
   );

   initial i_clk = 1'b0;
   always #5 i_clk = ~i_clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      total++;
      assert (obs === expv) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Issue one command from IDLE; returns at the falling edge in HOLD.
   task automatic send(input logic [2:0] op, input logic [3:0] a, input logic [3:0] b);
      chk("idle_ready", 32'(o_ready), 32'd1);
      chk("idle_valid", 32'(o_valid), 32'd0);
      i_valid = 1'b1;
      i_op    = op;
      i_a     = a;
      i_b     = b;
      @(posedge i_clk);
      @(negedge i_clk);
      i_valid = 1'b0;
      i_op    = 3'($urandom_range(0, 7));
      i_a     = 4'($urandom);
      i_b     = 4'($urandom);
      chk("exec_valid", 32'(o_valid), 32'd0);
      chk("exec_ready", 32'(o_ready), 32'd0);
      @(posedge i_clk);
      @(negedge i_clk);
      chk("hold_valid", 32'(o_valid), 32'd1);
      chk("hold_ready", 32'(o_ready), 32'd0);
   endtask

   task automatic res(input string tag, input logic [3:0] y, input logic ov, input logic err);
      chk({tag, "_y"},   32'(o_y),        32'(y));
      chk({tag, "_ov"},  32'(o_overflow), 32'(ov));
      chk({tag, "_err"}, 32'(o_err),      32'(err));
   endtask

   // Accept the held result; returns at the next falling edge, back in IDLE.
   task automatic complete(input logic clr, input int ops, input int bads);
      i_ready     = 1'b1;
      i_clr_stats = clr;
      @(posedge i_clk);
      @(negedge i_clk);
      i_ready     = 1'b0;
      i_clr_stats = 1'b0;
      chk("post_valid", 32'(o_valid),   32'd0);
      chk("post_ready", 32'(o_ready),   32'd1);
      chk("ops_cnt",    32'(o_ops_cnt), 32'(ops));
      chk("bad_cnt",    32'(o_bad_cnt), 32'(bads));
   endtask

   initial begin
      i_rst_n     = 1'b0;
      i_valid     = 1'b0;
      i_op        = 3'd0;
      i_a         = 4'd0;
      i_b         = 4'd0;
      i_ready     = 1'b0;
      i_clr_stats = 1'b0;

      // Reset state, before any clock edge
      #1;
      chk("rst_ready", 32'(o_ready),    32'd1);
      chk("rst_valid", 32'(o_valid),    32'd0);
      chk("rst_y",     32'(o_y),        32'd0);
      chk("rst_ov",    32'(o_overflow), 32'd0);
      chk("rst_err",   32'(o_err),      32'd0);
      chk("rst_ops",   32'(o_ops_cnt),  32'd0);
      chk("rst_bad",   32'(o_bad_cnt),  32'd0);
      repeat (2) @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);

      // Subtract: 3-5 = -2
      send(3'd0, 4'd3, 4'd5);
      res("sub_3_5", 4'hE, 1'b0, 1'b0);
      complete(1'b0, 1, 0);

      // Subtract: -8-1 overflows to +7
      send(3'd0, 4'h8, 4'h1);
      res("sub_8_1", 4'h7, 1'b1, 1'b0);
      complete(1'b0, 2, 1);

      // NAND
      send(3'd1, 4'hC, 4'hA);
      res("nand", 4'h7, 1'b0, 1'b0);
      complete(1'b0, 3, 1);

      // Starting ones of 1110_0000
      send(3'd2, 4'h0, 4'hE);
      res("ones_3", 4'h3, 1'b0, 1'b0);
      complete(1'b0, 4, 1);

      // Starting ones of all-ones vector
      send(3'd2, 4'hF, 4'hF);
      res("ones_8", 4'h8, 1'b0, 1'b0);
      complete(1'b0, 5, 1);

      // One-hot decode, bit 5 set
      send(3'd3, 4'h0, 4'h2);
      res("onehot_5", 4'h5, 1'b0, 1'b0);
      complete(1'b0, 6, 1);

      // One-hot decode, two bits set: lowest index 0, error
      send(3'd3, 4'h3, 4'h0);
      res("onehot_multi", 4'h0, 1'b0, 1'b1);
      complete(1'b0, 7, 2);

      // One-hot decode, no bit set
      send(3'd3, 4'h0, 4'h0);
      res("onehot_zero", 4'h0, 1'b0, 1'b0);
      complete(1'b0, 8, 2);

      // Illegal opcode
      send(3'd5, 4'h9, 4'h6);
      res("illegal", 4'h0, 1'b0, 1'b1);
      complete(1'b0, 9, 3);

      // Backpressure: result held 5 cycles while operands toggle
      send(3'd0, 4'h7, 4'h2);
      res("bp_start", 4'h5, 1'b0, 1'b0);
      for (int k = 0; k < 5; k++) begin
         i_a  = ~i_a;
         i_op = 3'd1;
         @(posedge i_clk);
         @(negedge i_clk);
         chk("bp_valid", 32'(o_valid), 32'd1);
         chk("bp_ready", 32'(o_ready), 32'd0);
         chk("bp_y",     32'(o_y),     32'h5);
      end
      complete(1'b0, 10, 3);

      // Asynchronous reset in the middle of EXEC
      i_valid = 1'b1;
      i_op    = 3'd0;
      i_a     = 4'h8;
      i_b     = 4'h1;
      @(posedge i_clk);
      #2;
      i_valid = 1'b0;
      i_rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(o_valid),   32'd0);
      chk("arst_ready", 32'(o_ready),   32'd1);
      chk("arst_ops",   32'(o_ops_cnt), 32'd0);
      chk("arst_bad",   32'(o_bad_cnt), 32'd0);
      chk("arst_y",     32'(o_y),       32'd0);
      @(negedge i_clk);
      i_rst_n = 1'b1;
      @(negedge i_clk);
      chk("arst_idle", 32'(o_ready), 32'd1);

      // Statistics: 256 flagged completions, wrap and saturation
      for (int k = 1; k <= 256; k++) begin
         send(3'd7, 4'h0, 4'h0);
         res("stat_illegal", 4'h0, 1'b0, 1'b1);
         complete(1'b0, k % 256, (k > 255) ? 255 : k);
      end

      // Clear on a completion edge beats the increment
      send(3'd7, 4'h0, 4'h0);
      complete(1'b1, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
